sdram_req_arbiter: RTL
======================

SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 Parameter REFRESH_CYCLES, default 1037, clock cycles between refresh ticks (7.8 us at 133 MHz).
REQ-002 Parameter ADR_W, default 24, SDRAM word address width {bank[1:0], row[12:0], col[8:0]}.
REQ-003 Parameter REF_MAX, default 8, saturation limit of pending refreshes.
REQ-004 CLK_133MHZ  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 wr_stb in 1 write request; wr_adr in ADR_W; wr_dat in 16; wr_ack out 1 accept pulse.
REQ-007 rd_stb in 1 read request; rd_adr in ADR_W; rd_ack out 1 accept pulse; rd_dat out 16; rd_vld out 1 data-valid pulse.
REQ-008 ctl_cmd out 2 command to SDRAM core: 00 NOP, 01 WRITE, 10 READ, 11 REFRESH.
REQ-009 ctl_adr out ADR_W; ctl_dat_w out 16; ctl_stb out 1; ctl_ack in 1 core accepted; ctl_done in 1 core finished; ctl_dat_r in 16 read data, valid with ctl_done.
REQ-010 ref_ovf out 1 sticky flag, pending refreshes hit REF_MAX.

Function
REQ-011 Refresh timer counts 0..REFRESH_CYCLES-1, wraps to 0, emits one tick on wrap.
REQ-012 Each tick increments ref_pend; each issued REFRESH decrements; tick and issue in same cycle leave ref_pend unchanged.
REQ-013 ref_pend saturates at REF_MAX; tick at REF_MAX sets ref_ovf, held until reset.
REQ-014 FSM states IDLE, ISSUE, WAIT_DONE.
REQ-015 IDLE: ref_pend>0 -> REFRESH; else single requester -> that requester; else wr_stb&rd_stb -> requester not granted last (round robin, initial preference WRITE); none -> stay IDLE.
REQ-016 IDLE->ISSUE: ctl_cmd/ctl_adr/ctl_dat_w registered, ctl_stb=1 the cycle after selection (1-cycle latency).
REQ-017 ISSUE: ctl_stb and all ctl_* held stable until ctl_ack=1; then ctl_stb=0, ->WAIT_DONE.
REQ-018 Same cycle as ctl_ack: wr_ack (WRITE) or rd_ack (READ) pulses 1 cycle; REFRESH decrements ref_pend.
REQ-019 Requesters hold stb, adr, dat stable until their ack; arbiter never samples a dropped stb after grant.
REQ-020 WAIT_DONE: on ctl_done ->IDLE; if command READ, rd_dat<=ctl_dat_r and rd_vld pulses 1 cycle after ctl_done.
REQ-021 ctl_ack and ctl_done asserted same cycle: treated as ack then done; FSM returns to IDLE directly.
REQ-022 ctl_cmd=00 whenever ctl_stb=0.
REQ-023 Refresh ticks during ISSUE/WAIT_DONE are counted, serviced at next IDLE before any data request.
REQ-024 Round-robin pointer updates only on WRITE/READ grant; REFRESH leaves it unchanged.
REQ-025 No new selection in the IDLE cycle that follows WAIT_DONE's exit is withheld: back-to-back grants allowed, one per completed command.

Reset
REQ-026 rst=0 at a clock edge: FSM->IDLE, timer=0, ref_pend=0, ref_ovf=0, round-robin->WRITE preferred.
REQ-027 Outputs at reset: ctl_stb=0, ctl_cmd=00, ctl_adr=0, ctl_dat_w=0, wr_ack=0, rd_ack=0, rd_vld=0, rd_dat=0.
REQ-028 Reset mid-transaction abandons command without waiting ctl_done; SDRAM core reset together.

Structure
REQ-029 Shared package holds ctl_cmd encodings (CMD_NOP/WRITE/READ/REFRESH), FSM state encodings, default REFRESH_CYCLES.
REQ-030 One sub-module: sdram_refresh_timer (timer, ref_pend, ref_ovf), with tick-issue decrement port.

Verification
REQ-031 wr_stb=1, wr_adr=0x000123, wr_dat=0xA55A, ctl_ack 2 cycles after ctl_stb -> ctl_cmd=01, ctl_adr=0x000123, ctl_dat_w=0xA55A held; wr_ack pulses with ctl_ack.
REQ-032 rd_stb=1, rd_adr=0x010040, ctl_done with ctl_dat_r=0x1234 -> ctl_cmd=10; rd_vld 1 cycle later, rd_dat=0x1234.
REQ-033 wr_stb and rd_stb held continuously, ack/done immediate -> grants alternate WRITE,READ,WRITE,READ starting WRITE.
REQ-034 REFRESH_CYCLES=16, requests continuous -> REFRESH issued within one command of each tick, before pending data request; ref_pend returns to 0.
REQ-035 REFRESH_CYCLES=16, ctl_ack withheld 200 cycles -> ref_pend saturates 8, ref_ovf=1 until rst=0.
REQ-036 rst=0 for one cycle during WAIT_DONE of a READ -> next cycle all outputs at REQ-027 values, no rd_vld.

Source files
------------

// File: rtl/sdram_req_arbiter_pkg.sv
// Shared encodings for the SDRAM request arbiter: core command codes, arbiter
// FSM states and the default refresh interval.
package sdram_req_arbiter_pkg;

  // 7.8 us at 133 MHz
  localparam int REFRESH_CYCLES_DEF = 1037;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_WRITE   = 2'b01,
    CMD_READ    = 2'b10,
    CMD_REFRESH = 2'b11
  } ctl_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh tick generator with a saturating count of refreshes still
// owed to the SDRAM and a sticky overflow flag for ticks that were lost.
module sdram_refresh_timer
  import sdram_req_arbiter_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int REF_MAX        = 8,
  parameter int PEND_W         = $clog2(REF_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_issue,
  output logic [PEND_W-1:0] ref_pend,
  output logic              ref_ovf
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      ref_pend <= '0;
      ref_ovf  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      // a tick and an issued refresh in the same cycle cancel out
      if (tick && !ref_issue) begin
        if (ref_pend == PEND_W'(REF_MAX))
          ref_ovf <= 1'b1;
        else
          ref_pend <= ref_pend + 1'b1;
      end else if (!tick && ref_issue && (ref_pend != '0)) begin
        ref_pend <= ref_pend - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates one write and one read requester plus periodic refresh onto a
// single SDRAM core command port; refresh wins, data requests round-robin.
//
// state        | meaning
// ST_IDLE      | no command outstanding, choose the next one
// ST_ISSUE     | ctl_stb high with command held, waiting for ctl_ack
// ST_WAIT_DONE | core accepted the command, waiting for ctl_done
module sdram_req_arbiter
  import sdram_req_arbiter_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int ADR_W          = 24,
  parameter int REF_MAX        = 8
) (
  input  logic             CLK_133MHZ,
  input  logic             rst,
  input  logic             wr_stb,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [15:0]      wr_dat,
  output logic             wr_ack,
  input  logic             rd_stb,
  input  logic [ADR_W-1:0] rd_adr,
  output logic             rd_ack,
  output logic [15:0]      rd_dat,
  output logic             rd_vld,
  output logic [1:0]       ctl_cmd,
  output logic [ADR_W-1:0] ctl_adr,
  output logic [15:0]      ctl_dat_w,
  output logic             ctl_stb,
  input  logic             ctl_ack,
  input  logic             ctl_done,
  input  logic [15:0]      ctl_dat_r,
  output logic             ref_ovf
);

  localparam int PEND_W = $clog2(REF_MAX + 1);

  arb_state_e        state;
  ctl_cmd_e          cur_cmd;
  logic              rr_rd_pref;
  logic              issue_ack;
  logic              ref_issue;
  logic [PEND_W-1:0] ref_pend;

  sdram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .REF_MAX        (REF_MAX),
    .PEND_W         (PEND_W)
  ) u_refresh_timer (
    .clk       (CLK_133MHZ),
    .rst       (rst),
    .ref_issue (ref_issue),
    .ref_pend  (ref_pend),
    .ref_ovf   (ref_ovf)
  );

  // Acks follow ctl_ack combinationally so a requester can drop its strobe
  // before the FSM is back in ST_IDLE, even when ack and done coincide.
  assign issue_ack = rst && (state == ST_ISSUE) && ctl_ack;
  assign wr_ack    = issue_ack && (cur_cmd == CMD_WRITE);
  assign rd_ack    = issue_ack && (cur_cmd == CMD_READ);
  assign ref_issue = issue_ack && (cur_cmd == CMD_REFRESH);
  assign ctl_cmd   = ctl_stb ? cur_cmd : CMD_NOP;

  always_ff @(posedge CLK_133MHZ) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_cmd    <= CMD_NOP;
      ctl_stb    <= 1'b0;
      ctl_adr    <= '0;
      ctl_dat_w  <= '0;
      rd_dat     <= '0;
      rd_vld     <= 1'b0;
      rr_rd_pref <= 1'b0;
    end else begin
      rd_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ref_pend != '0) begin
            cur_cmd   <= CMD_REFRESH;
            ctl_adr   <= '0;
            ctl_dat_w <= '0;
            ctl_stb   <= 1'b1;
            state     <= ST_ISSUE;
          end else if (wr_stb && (!rd_stb || !rr_rd_pref)) begin
            cur_cmd    <= CMD_WRITE;
            ctl_adr    <= wr_adr;
            ctl_dat_w  <= wr_dat;
            ctl_stb    <= 1'b1;
            rr_rd_pref <= 1'b1;
            state      <= ST_ISSUE;
          end else if (rd_stb) begin
            cur_cmd    <= CMD_READ;
            ctl_adr    <= rd_adr;
            ctl_dat_w  <= '0;
            ctl_stb    <= 1'b1;
            rr_rd_pref <= 1'b0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ctl_ack) begin
            ctl_stb <= 1'b0;
            if (ctl_done) begin
              state <= ST_IDLE;
              if (cur_cmd == CMD_READ) begin
                rd_dat <= ctl_dat_r;
                rd_vld <= 1'b1;
              end
            end else begin
              state <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (ctl_done) begin
            state <= ST_IDLE;
            if (cur_cmd == CMD_READ) begin
              rd_dat <= ctl_dat_r;
              rd_vld <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
